// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port RAM with
// byte-lane write enables and 1-cycle registered read data.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin contention
// resolution; otherwise requester 0 has fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_BYTES = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                req,
  input  logic [1:0]                lock,
  input  logic [2*DATA_BYTES-1:0]   we,
  input  logic [2*ADDR_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0]   wdata,
  output logic [1:0]                gnt,
  output logic [1:0]                rvalid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [DATA_BYTES-1:0]     ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_wdata,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_d;
  logic [1:0]  rvalid_q;
  logic        pref1;  // high when requester 1 wins a FREE-state contention

`ifdef MEM_ARBITER_RR_EN
  logic ptr_q, ptr_d;

  // Round-robin pointer: after a FREE-state grant the other requester is preferred.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == FREE) begin
      if (gnt_d[0])      ptr_d = 1'b1;
      else if (gnt_d[1]) ptr_d = 1'b0;
    end
  end

  // Pointer register, cleared to requester 0 on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  assign pref1 = ptr_q;
`else
  assign pref1 = 1'b0;
`endif

  // Owner state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FREE;
    else       state_q <= state_d;
  end

  // Grant selection and owner next-state.
  always_comb begin
    gnt_d   = '0;
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (req == 2'b11) gnt_d = pref1 ? 2'b10 : 2'b01;
        else              gnt_d = req;
        if (gnt_d[0] && lock[0])      state_d = OWN0;
        else if (gnt_d[1] && lock[1]) state_d = OWN1;
      end
      OWN0: begin
        // Owner wins whenever it asks; the other side fills idle owner cycles.
        if (req[0]) gnt_d = 2'b01;
        else        gnt_d = {req[1], 1'b0};
        if (!lock[0]) state_d = FREE;
      end
      OWN1: begin
        if (req[1]) gnt_d = 2'b10;
        else        gnt_d = {1'b0, req[0]};
        if (!lock[1]) state_d = FREE;
      end
      default: begin
        gnt_d   = '0;
        state_d = FREE;
      end
    endcase
    if (reset) gnt_d = '0;
  end

  // RAM port mux: granted requester's slices, requester 0 slices when idle.
  always_comb begin
    ram_we    = '0;
    ram_addr  = addr[0 +: ADDR_WIDTH];
    ram_wdata = wdata[0 +: DATA_WIDTH];
    if (gnt_d[1]) begin
      ram_we    = we[DATA_BYTES +: DATA_BYTES];
      ram_addr  = addr[ADDR_WIDTH +: ADDR_WIDTH];
      ram_wdata = wdata[DATA_WIDTH +: DATA_WIDTH];
    end else if (gnt_d[0]) begin
      ram_we    = we[0 +: DATA_BYTES];
    end
  end

  // Read-valid tracks the grant one cycle later, matching RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rvalid_q <= '0;
    else       rvalid_q <= gnt_d;
  end

  assign gnt    = gnt_d;
  assign rvalid = rvalid_q;
  assign rdata  = ram_rdata;

endmodule
